// File: rtl/muldiv_seq_8bit.sv
// Sequential unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring)
// sharing a single 8-bit add/subtract slice; fixed 8-iteration latency.
module muldiv_seq_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       div_by_zero
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          op_r, op_nxt;
  logic [W-1:0]  opnd_r, opnd_nxt;   // adder's second operand: a for MUL, b for DIV
  logic [W-1:0]  hi_r, hi_nxt;       // acc (MUL) / rem (DIV)
  logic [W-1:0]  lo_r, lo_nxt;       // mq (MUL) / q (DIV)
  logic [CW-1:0] count, count_nxt;
  logic          busy_nxt, done_nxt, dbz_nxt;
  logic [W-1:0]  res_hi_nxt, res_lo_nxt;

  logic [W-1:0]  shifted, add_x, add_y, sum, acc_t, step_hi, step_lo;
  logic          cin, c9, cout, qbit, mul_carry;

  // Shared add/sub slice plus one iteration of the selected algorithm
  always_comb begin
    shifted   = {hi_r[W-2:0], lo_r[W-1]};
    cin       = op_r;
    add_x     = op_r ? shifted : hi_r;
    add_y     = opnd_r ^ {W{cin}};
    {c9, sum} = (W+1)'(add_x) + (W+1)'(add_y) + (W+1)'(cin);
    // On subtract the slice reports borrow on Cout
    cout      = op_r ? ~c9 : c9;
    qbit      = 1'b0;
    mul_carry = 1'b0;
    acc_t     = hi_r;
    if (op_r) begin
      qbit    = hi_r[W-1] | ~cout;
      step_hi = qbit ? sum : shifted;
      step_lo = {lo_r[W-2:0], qbit};
    end else begin
      mul_carry = lo_r[0] & cout;
      acc_t     = lo_r[0] ? sum : hi_r;
      step_hi   = {mul_carry, acc_t[W-1:1]};
      step_lo   = {acc_t[0], lo_r[W-1:1]};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_r;
    opnd_nxt   = opnd_r;
    hi_nxt     = hi_r;
    lo_nxt     = lo_r;
    count_nxt  = count;
    res_hi_nxt = result_hi;
    res_lo_nxt = result_lo;
    dbz_nxt    = div_by_zero;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt = RUN;
          op_nxt    = op;
          opnd_nxt  = op ? b : a;
          hi_nxt    = '0;
          lo_nxt    = op ? a : b;
          count_nxt = '0;
        end
      end
      RUN: begin
        hi_nxt    = step_hi;
        lo_nxt    = step_lo;
        count_nxt = count + CW'(1);
        if (count == CW'(W - 1)) begin
          state_nxt  = DONE;
          res_hi_nxt = step_hi;
          res_lo_nxt = step_lo;
          dbz_nxt    = op_r && (opnd_r == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r        <= 1'b0;
      opnd_r      <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      op_r        <= op_nxt;
      opnd_r      <= opnd_nxt;
      hi_r        <= hi_nxt;
      lo_r        <= lo_nxt;
      count       <= count_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      result_hi   <= res_hi_nxt;
      result_lo   <= res_lo_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_8bit.sv
// Bench for muldiv_seq_8bit: arithmetic/timing model checked every cycle,
// plus hand-computed literal results for directed cases.
module tb_muldiv_seq_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, div_by_zero;
  logic [7:0] result_hi, result_lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq_8bit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request completes 8 edges later with plain arithmetic results
  bit         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [7:0] m_hi = 8'h00, m_lo = 8'h00, p_hi = 8'h00, p_lo = 8'h00;
  logic [15:0] prod;
  int         m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = 8'h00; m_lo = 8'h00; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_left = 8;
        m_busy = 1'b1;
        if (op) begin
          if (b == 8'h00) begin
            p_hi = a; p_lo = 8'hFF; p_dbz = 1'b1;
          end else begin
            p_hi = a % b; p_lo = a / b; p_dbz = 1'b0;
          end
        end else begin
          prod = 16'(a) * 16'(b);
          p_hi = prod[15:8]; p_lo = prod[7:0]; p_dbz = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", 16'(busy), 16'(m_busy));
    chk("done", 16'(done), 16'(m_done));
    chk("result_hi", 16'(result_hi), 16'(m_hi));
    chk("result_lo", 16'(result_lo), 16'(m_lo));
    chk("div_by_zero", 16'(div_by_zero), 16'(m_dbz));
  end

  task automatic launch(input logic o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  // Waits (bounded) for done; counts busy cycles seen on the way
  task automatic wait_done(input string nm, output int bc);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) bc++;
      @(negedge clk);
    end
    if (!done) chk({nm, "_done_timeout"}, 16'(done), 16'd1);
  endtask

  task automatic chk_res(input string nm, input logic [7:0] h, input logic [7:0] l, input logic z);
    chk({nm, "_hi"}, 16'(result_hi), 16'(h));
    chk({nm, "_lo"}, 16'(result_lo), 16'(l));
    chk({nm, "_dbz"}, 16'(div_by_zero), 16'(z));
  endtask

  int bc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk_res("reset", 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    launch(1'b0, 8'd13, 8'd11);
    wait_done("mul13x11", bc);
    chk("mul13x11_busy_cycles", 16'(bc), 16'd8);
    chk_res("mul13x11", 8'h00, 8'h8F, 1'b0);

    launch(1'b0, 8'hFF, 8'hFF);
    wait_done("mulffxff", bc);
    chk_res("mulffxff", 8'hFE, 8'h01, 1'b0);
    launch(1'b0, 8'h00, 8'hC3);
    wait_done("mul0xc3", bc);
    chk_res("mul0xc3", 8'h00, 8'h00, 1'b0);

    launch(1'b1, 8'd200, 8'd7);
    wait_done("div200_7", bc);
    chk("div200_7_busy_cycles", 16'(bc), 16'd8);
    chk_res("div200_7", 8'h04, 8'h1C, 1'b0);
    launch(1'b1, 8'hFF, 8'hC8);
    wait_done("divff_c8", bc);
    chk_res("divff_c8", 8'h37, 8'h01, 1'b0);

    launch(1'b1, 8'hA5, 8'h00);
    wait_done("div_by0", bc);
    chk_res("div_by0", 8'hA5, 8'hFF, 1'b1);
    launch(1'b0, 8'd2, 8'd3);
    wait_done("mul2x3", bc);
    chk_res("mul2x3", 8'h00, 8'h06, 1'b0);

    // starts during RUN are ignored
    launch(1'b1, 8'd200, 8'd7);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'h11; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start", bc);
    chk_res("ignored_start", 8'h04, 8'h1C, 1'b0);
    // start held in the DONE cycle is accepted back-to-back
    start = 1'b1; op = 1'b0; a = 8'd9; b = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("back_to_back", bc);
    chk("back_to_back_busy_cycles", 16'(bc), 16'd8);
    chk_res("back_to_back", 8'h00, 8'h3F, 1'b0);

    // async reset mid-RUN
    launch(1'b0, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk_res("midrst", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 16'(done), 16'd0);
    end
    launch(1'b1, 8'hFF, 8'hC8);
    wait_done("after_rst", bc);
    chk("after_rst_busy_cycles", 16'(bc), 16'd8);
    chk_res("after_rst", 8'h37, 8'h01, 1'b0);

    // randomized traffic, checked by the every-cycle model comparison
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      op    = 1'($urandom);
      a     = 8'($urandom);
      b     = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
